// File: rtl/tone_decoder.sv
// Measures the period of a square-wave tone input and decodes it to a note code.
// Optional duty-level estimate on level_out is built when TONE_LEVEL_EN is defined.
module tone_decoder #(
    parameter int CLK_HZ      = 50_000_000,
    parameter int TOL_SHIFT   = 6,
    parameter int STABLE_N    = 4,
    parameter int SILENCE_CYC = 2_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tone_in,
    output logic [4:0] note_code,
    output logic       note_valid,
    output logic       locked,
    output logic [2:0] level_out
);
    localparam int STAB_W = $clog2(STABLE_N + 1);
    localparam int SIL_W  = $clog2(SILENCE_CYC + 1);
    localparam logic [STAB_W-1:0] STAB_N   = STAB_W'(STABLE_N);
    localparam logic [SIL_W-1:0]  SIL_N    = SIL_W'(SILENCE_CYC);
    localparam logic [4:0] CODE_PAUSE   = 5'd0;
    localparam logic [4:0] CODE_UNKNOWN = 5'd31;

    localparam int FREQ [16] = '{262, 294, 330, 349, 392, 415, 440, 494,
                                 523, 587, 659, 698, 784, 831, 880, 988};
    localparam logic [17:0] PERIOD [16] = '{
        18'(CLK_HZ / FREQ[0]),  18'(CLK_HZ / FREQ[1]),  18'(CLK_HZ / FREQ[2]),  18'(CLK_HZ / FREQ[3]),
        18'(CLK_HZ / FREQ[4]),  18'(CLK_HZ / FREQ[5]),  18'(CLK_HZ / FREQ[6]),  18'(CLK_HZ / FREQ[7]),
        18'(CLK_HZ / FREQ[8]),  18'(CLK_HZ / FREQ[9]),  18'(CLK_HZ / FREQ[10]), 18'(CLK_HZ / FREQ[11]),
        18'(CLK_HZ / FREQ[12]), 18'(CLK_HZ / FREQ[13]), 18'(CLK_HZ / FREQ[14]), 18'(CLK_HZ / FREQ[15])};

    typedef enum logic [1:0] {WAIT_EDGE, MEASURE, CLASSIFY, QUALIFY} state_t;

    state_t             r_state, w_state_next;
    logic               r_sync1, r_sync2, r_sync3, r_strobe;
    logic [17:0]        r_cnt, w_cnt_next, r_period;
    logic [SIL_W-1:0]   r_sil, w_sil_next;
    logic [3:0]         r_idx;
    logic [4:0]         r_cand, r_prev_cand, r_note_code;
    logic [STAB_W-1:0]  r_stab, w_stab_next;
    logic               r_valid, r_locked;
    logic [17:0]        w_p, w_diff;
    logic               w_hit, w_latch, w_silence, w_commit;

    assign w_cnt_next = (r_cnt == '1) ? r_cnt : r_cnt + 18'd1;
    assign w_sil_next = (r_sil == '1) ? r_sil : r_sil + SIL_W'(1);

    assign w_p    = PERIOD[r_idx];
    assign w_diff = (r_period >= w_p) ? r_period - w_p : w_p - r_period;
    assign w_hit  = (w_diff <= (w_p >> TOL_SHIFT));

    always_comb begin
        if (r_cand == r_prev_cand)
            w_stab_next = (r_stab == STAB_N) ? r_stab : r_stab + STAB_W'(1);
        else
            w_stab_next = STAB_W'(1);
    end

    assign w_commit = (r_state == QUALIFY) && (w_stab_next == STAB_N) && (r_cand != r_note_code);

    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        w_silence    = 1'b0;
        case (r_state)
            WAIT_EDGE: begin
                if (r_strobe)
                    w_state_next = MEASURE;
                else if (w_sil_next == SIL_N)
                    w_silence = 1'b1;
            end
            MEASURE: begin
                if (r_strobe) begin
                    w_latch      = 1'b1;
                    w_state_next = CLASSIFY;
                end else if (w_sil_next == SIL_N) begin
                    w_silence    = 1'b1;
                    w_state_next = WAIT_EDGE;
                end
            end
            CLASSIFY: begin
                if (r_idx == 4'd15)
                    w_state_next = QUALIFY;
            end
            QUALIFY:  w_state_next = MEASURE;
            default:  w_state_next = WAIT_EDGE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= WAIT_EDGE;
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_sync3     <= 1'b0;
            r_strobe    <= 1'b0;
            r_cnt       <= '0;
            r_sil       <= '0;
            r_period    <= '0;
            r_idx       <= '0;
            r_cand      <= '0;
            r_prev_cand <= '0;
            r_stab      <= '0;
            r_note_code <= CODE_PAUSE;
            r_valid     <= 1'b0;
            r_locked    <= 1'b0;
        end else begin
            r_sync1  <= tone_in;
            r_sync2  <= r_sync1;
            r_sync3  <= r_sync2;
            r_strobe <= r_sync2 & ~r_sync3;
            r_state  <= w_state_next;
            r_valid  <= 1'b0;
            r_cnt    <= r_strobe ? '0 : w_cnt_next;
            r_sil    <= r_strobe ? '0 : w_sil_next;

            if (w_latch) begin
                r_period <= w_cnt_next;
                r_idx    <= '0;
                r_cand   <= CODE_UNKNOWN;
            end

            // First matching table entry wins; later hits are ignored.
            if (r_state == CLASSIFY) begin
                r_idx <= r_idx + 4'd1;
                if (w_hit && r_cand == CODE_UNKNOWN)
                    r_cand <= {1'b0, r_idx} + 5'd1;
            end

            if (r_state == QUALIFY) begin
                r_prev_cand <= r_cand;
                r_stab      <= w_stab_next;
                if (w_commit) begin
                    r_note_code <= r_cand;
                    r_valid     <= 1'b1;
                    r_locked    <= (r_cand != CODE_UNKNOWN);
                end
            end

            if (w_silence) begin
                r_prev_cand <= CODE_PAUSE;
                r_stab      <= '0;
                if (r_note_code != CODE_PAUSE) begin
                    r_note_code <= CODE_PAUSE;
                    r_valid     <= 1'b1;
                    r_locked    <= 1'b0;
                end
            end
        end
    end

    assign note_code  = r_note_code;
    assign note_valid = r_valid;
    assign locked     = r_locked;

`ifdef TONE_LEVEL_EN
    logic [17:0] r_hcnt, r_high;
    logic        r_lvl_run;
    logic [2:0]  r_lvl_l, r_lvl_best, r_level, w_best_next;
    logic [9:0]  r_lvl_f;
    logic [19:0] w_thr;
    logic        w_lvl_hit, w_lvl_start, w_lvl_clear;

    // Threshold for level L is f*L - f/2 high cycles.
    assign w_thr       = ({10'd0, r_lvl_f} * {17'd0, r_lvl_l}) - {11'd0, r_lvl_f[9:1]};
    assign w_lvl_hit   = ({2'b00, r_high} >= w_thr);
    assign w_best_next = w_lvl_hit ? r_lvl_l : r_lvl_best;
    assign w_lvl_start = (r_state == QUALIFY) && (w_stab_next == STAB_N) && (r_cand != CODE_UNKNOWN)
                         && (w_commit || r_cand == r_note_code);
    assign w_lvl_clear = (w_commit && r_cand == CODE_UNKNOWN) || (w_silence && r_note_code != CODE_PAUSE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hcnt     <= '0;
            r_high     <= '0;
            r_lvl_run  <= 1'b0;
            r_lvl_l    <= '0;
            r_lvl_best <= '0;
            r_lvl_f    <= '0;
            r_level    <= '0;
        end else begin
            if (r_strobe) begin
                r_high <= r_hcnt;
                r_hcnt <= {17'd0, r_sync3};
            end else if (r_hcnt != '1) begin
                r_hcnt <= r_hcnt + {17'd0, r_sync3};
            end

            if (w_lvl_clear) begin
                r_level   <= '0;
                r_lvl_run <= 1'b0;
            end else if (w_lvl_start) begin
                r_lvl_run  <= 1'b1;
                r_lvl_l    <= 3'd1;
                r_lvl_best <= 3'd0;
                r_lvl_f    <= 10'(FREQ[r_cand[3:0] - 4'd1]);
            end else if (r_lvl_run) begin
                r_lvl_best <= w_best_next;
                r_lvl_l    <= r_lvl_l + 3'd1;
                if (r_lvl_l == 3'd7) begin
                    r_lvl_run <= 1'b0;
                    r_level   <= w_best_next;
                end
            end
        end
    end

    assign level_out = r_level;
`else
    assign level_out = 3'd0;
`endif

endmodule

// File: tb/tb_tone_decoder.sv
// Bench for tone_decoder: scaled clock, per-cycle reference model plus directed literal checks.
module tb_tone_decoder;
    localparam int CLK_HZ = 250_000;
    localparam int TOL    = 6;
    localparam int STAB   = 4;
    localparam int SIL    = 3000;
    localparam int FREQ [16] = '{262, 294, 330, 349, 392, 415, 440, 494,
                                 523, 587, 659, 698, 784, 831, 880, 988};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tone_in = 1'b0;
    logic [4:0] note_code;
    logic       note_valid;
    logic       locked;
    logic [2:0] level_out;

    int checks = 0;
    int failures = 0;
    int vcount = 0;
    int fail_prints = 0;

    tone_decoder #(.CLK_HZ(CLK_HZ), .TOL_SHIFT(TOL), .STABLE_N(STAB), .SILENCE_CYC(SIL)) dut (
        .clk(clk), .rst(rst), .tone_in(tone_in),
        .note_code(note_code), .note_valid(note_valid), .locked(locked), .level_out(level_out)
    );

    always #5 clk = ~clk;

    // Nearest-note lookup straight from the frequency list and tolerance rule.
    function automatic int classify(input int p);
        for (int n = 0; n < 16; n++) begin
            int pn;
            int d;
            pn = CLK_HZ / FREQ[n];
            d  = (p > pn) ? p - pn : pn - p;
            if (d <= (pn >> TOL)) return n + 1;
        end
        return 31;
    endfunction

    function automatic int exp_level(input int code, input int high);
`ifdef TONE_LEVEL_EN
        int f;
        int best;
        if (code < 1 || code > 16) return 0;
        f = FREQ[code - 1];
        best = 0;
        for (int l = 1; l <= 7; l++)
            if (high >= f * l - f / 2) best = l;
        return best;
`else
        return 0;
`endif
    endfunction

    // Reference model state: event level (strobe times, pending decisions, stability run).
    int   cyc = 0, last_ref = 0, busy_until = 0, stab = 0, prev_c = 0;
    int   due_q[$];
    int   cand_q[$];
    bit   have_ref = 0, prev_in = 0, m_valid = 0;
    bit   rd[3] = '{0, 0, 0};
    logic [4:0] m_code = 5'd0;

    task automatic qualify(input int c);
        stab = (c == prev_c) ? ((stab < STAB) ? stab + 1 : stab) : 1;
        prev_c = c;
        if (stab == STAB && c != int'(m_code)) begin
            m_code  = 5'(c);
            m_valid = 1;
        end
    endtask

    initial begin
        forever begin
            bit strobe;
            bit busy;
            int elapsed;
            @(posedge clk);
            #1;
            cyc++;
            m_valid = 0;
            if (!rst) begin
                m_code = 5'd0; stab = 0; prev_c = 0; have_ref = 0; prev_in = 0;
                rd = '{0, 0, 0}; last_ref = cyc; busy_until = cyc;
                due_q.delete(); cand_q.delete();
            end else begin
                strobe  = rd[2];
                rd[2]   = rd[1];
                rd[1]   = rd[0];
                rd[0]   = tone_in && !prev_in;
                prev_in = tone_in;
                elapsed = cyc - last_ref;
                busy    = (cyc <= busy_until);
                if (due_q.size() > 0 && due_q[0] == cyc) begin
                    qualify(cand_q[0]);
                    void'(due_q.pop_front());
                    void'(cand_q.pop_front());
                end
                if (strobe) begin
                    if (!busy) begin
                        if (have_ref) begin
                            due_q.push_back(cyc + 17);
                            cand_q.push_back(classify(elapsed));
                            busy_until = cyc + 17;
                        end else begin
                            have_ref = 1;
                        end
                    end
                    last_ref = cyc;
                end else if (!busy && elapsed == SIL) begin
                    have_ref = 0; prev_c = 0; stab = 0;
                    if (m_code != 5'd0) begin
                        m_code  = 5'd0;
                        m_valid = 1;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            bit lvl_bad;
            bit m_locked;
            @(negedge clk);
            m_locked = (m_code >= 5'd1 && m_code <= 5'd16);
`ifdef TONE_LEVEL_EN
            lvl_bad = 1'b0;
`else
            lvl_bad = (level_out !== 3'd0);
`endif
            if (note_valid === 1'b1) vcount++;
            checks++;
            if (note_code !== m_code || note_valid !== m_valid || locked !== m_locked || lvl_bad) begin
                failures++;
                if (fail_prints < 20) begin
                    fail_prints++;
                    $display("FAIL per_cycle t=%0t got code=%0d valid=%0b locked=%0b level=%0d want code=%0d valid=%0b locked=%0b",
                             $time, note_code, note_valid, locked, level_out, m_code, m_valid, m_locked);
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic step(input logic v);
        @(negedge clk);
        #1 tone_in = v;
    endtask

    task automatic hold(input logic v, input int n);
        repeat (n) step(v);
    endtask

    task automatic tone(input int per, input int hi, input int n);
        repeat (n) begin
            hold(1'b1, hi);
            hold(1'b0, per - hi);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("reset_code", note_code, 0);
        chk("reset_valid", note_valid, 0);
        chk("reset_locked", locked, 0);
        chk("reset_level", level_out, 0);
        @(negedge clk);
        #1 rst = 1'b1;
        hold(1'b0, 10);

        // M_E: commit 11 after four measured periods.
        vcount = 0;
        tone(379, 330, 5);
        chk("me_code", note_code, 11);
        chk("me_locked", locked, 1);
        chk("me_pulses", vcount, 1);
        chk("me_level", level_out, exp_level(11, 330));

        // Silence with input low.
        vcount = 0;
        hold(1'b0, 3100);
        chk("sil_code", note_code, 0);
        chk("sil_locked", locked, 0);
        chk("sil_pulses", vcount, 1);

        // L_Gs after silence.
        vcount = 0;
        tone(602, 301, 5);
        chk("lgs_code", note_code, 6);
        chk("lgs_pulses", vcount, 1);
        chk("lgs_level", level_out, exp_level(6, 301));

        // 600 Hz matches nothing.
        vcount = 0;
        tone(416, 208, 5);
        chk("unk_code", note_code, 31);
        chk("unk_locked", locked, 0);
        chk("unk_pulses", vcount, 1);
        chk("unk_level", level_out, 0);

        // Alternating M_C / M_E never stabilises.
        vcount = 0;
        repeat (5) begin
            tone(478, 239, 1);
            tone(379, 189, 1);
        end
        chk("alt_code", note_code, 31);
        chk("alt_pulses", vcount, 0);

        // L_A lock, then reset mid-measure and relock.
        vcount = 0;
        tone(568, 284, 5);
        chk("la_code", note_code, 7);
        chk("la_locked", locked, 1);
        hold(1'b1, 284);
        hold(1'b0, 100);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_code", note_code, 0);
        chk("rst_locked", locked, 0);
        chk("rst_valid", note_valid, 0);
        chk("rst_level", level_out, 0);
        hold(1'b0, 3);
        @(negedge clk);
        #1 rst = 1'b1;
        hold(1'b0, 184);
        vcount = 0;
        tone(568, 284, 4);
        chk("relock_early_code", note_code, 0);
        chk("relock_early_pulses", vcount, 0);
        tone(568, 284, 1);
        chk("relock_code", note_code, 7);
        chk("relock_pulses", vcount, 1);
        chk("relock_level", level_out, exp_level(7, 284));

        // Boundary table entries.
        tone(954, 477, 5);
        chk("lc_code", note_code, 1);
        chk("lc_level", level_out, exp_level(1, 477));
        tone(253, 126, 5);
        chk("mb_code", note_code, 16);
        chk("mb_locked", locked, 1);
        chk("mb_level", level_out, exp_level(16, 126));

        // Constant-high input decodes as pause.
        vcount = 0;
        hold(1'b1, 3100);
        chk("high_code", note_code, 0);
        chk("high_pulses", vcount, 1);
        chk("high_level", level_out, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tone_decoder.md
Name: tone_decoder

Overview:
- Receive-side counterpart of the piezo tone generator: measures an incoming square-wave tone and decodes it back to a note code.
- Decoded range: the 16 generator notes L_C..M_B, including L_Gs and M_Gs, plus pause.
- Used for loopback self-test of the music path and for sensing an external tone input pin.
- Runs on the 50 MHz system clock; output feeds debug LEDs/7-seg and the game-state monitor.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency; nominal note period P_n = CLK_HZ / f_n (integer divide).
- TOL_SHIFT, 6, match window is |period − P_n| <= P_n >> TOL_SHIFT (about 1.56%).
- STABLE_N, 4, consecutive identical classifications required before a code is committed.
- SILENCE_CYC, 2_500_000, cycles (50 ms) without a rising edge before pause is declared.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- tone_in  in  1  asynchronous square-wave input.
- note_code  out  5  committed note: 0=pause, 1 L_C, 2 L_D, 3 L_E, 4 L_F, 5 L_G, 6 L_Gs, 7 L_A, 8 L_B, 9 M_C, 10 M_D, 11 M_E, 12 M_F, 13 M_G, 14 M_Gs, 15 M_A, 16 M_B, 31 unknown.
- note_valid  out  1  one-cycle pulse when note_code changes.
- locked  out  1  high while the committed code is a note 1..16.
- level_out  out  3  estimated duty level (see Optional Feature).

Behaviour:
- Reset (async, rst=0): all outputs 0, note_code=0, state=WAIT_EDGE, all counters 0, stability count 0.
- Input conditioning:
  - tone_in passes a 2-FF synchronizer, then a registered rising-edge detect.
  - Edge strobe is asserted 3 clk after the input transition.
- Period counter:
  - 18 bits, increments every cycle, cleared on each edge strobe.
  - Saturates at 2^18−1 (a saturated value never matches any note).
- FSM states:
  - WAIT_EDGE: first edge after reset or silence only starts the counter; go to MEASURE.
  - MEASURE: on an edge strobe, latch the period, clear the counter, go to CLASSIFY.
  - CLASSIFY: compare the latched period against table entries 1..16, one entry per cycle (16 cycles). First match wins; no match gives candidate 31. Go to QUALIFY.
  - QUALIFY, one cycle:
    - If candidate equals the previous candidate, stability count increments (saturates at STABLE_N); otherwise it resets to 1.
    - When the count reaches STABLE_N and candidate != note_code, commit it: note_code updates on the next cycle, with note_valid high that same cycle.
    - Return to MEASURE.
- Edge strobe during CLASSIFY/QUALIFY:
  - Cannot occur for in-range notes (minimum period 50,607 cycles).
  - If it does, the counter still clears on the strobe; the new period is measured from that edge and the pending classification completes.
- Silence:
  - Counter reaching SILENCE_CYC in MEASURE or WAIT_EDGE forces candidate 0 and stability count 0.
  - If note_code != 0, commit 0 with a note_valid pulse.
  - Go to WAIT_EDGE.
  - Constant-high and constant-low inputs (generator level 0, full duty, or pause) both decode as pause.
- locked = (note_code >= 1 && note_code <= 16), registered with note_code.
- Reset mid-operation: immediate return to reset values; no note_valid pulse is generated by reset.

Optional Feature:
- Macro: TONE_LEVEL_EN.
- Defined:
  - Count synchronized-high cycles per period, latched at each edge strobe.
  - After a note commit or a re-confirmed classification, a 7-cycle sequential compare gives level_out = largest L in 1..7 with high_cycles >= f_n*L − f_n/2, where f_n is the table frequency in Hz; 0 if none qualifies.
  - level_out updates with the QUALIFY result and is 0 whenever note_code is 0 or 31.
- Not defined: level_out is tied to 0 and the high-time counter is not built.

Test Plan:
- 659 Hz input (period 75,872 cycles, high 1,977 cycles): after 4 periods + 18 cycles, note_code=11, one note_valid pulse, locked=1, level_out=3 with TONE_LEVEL_EN.
- 600 Hz input (period 83,333 cycles): after 4 periods, note_code=31, locked=0.
- Alternating periods 95,602 (M_C) and 75,872 (M_E): no commit; note_code stays at its prior value with no note_valid.
- M_E locked, then tone_in held low: exactly SILENCE_CYC cycles after the last edge, note_code=0 with one note_valid pulse; a subsequent 415 Hz input commits note_code=6 after 4 full periods.
- rst pulsed low mid-MEASURE while locked on L_A: outputs go to 0 immediately; relock on 7 requires 4 fresh periods.
- 262 Hz input (period 190,839 cycles) and 988 Hz input (period 50,607 cycles): codes 1 and 16 respectively (boundary entries, no counter saturation).
